// File: rtl/seven_segment_scan_driver_if.sv
// seven_segment_scan_driver_if: load handshake, live display controls and scanned display outputs
interface seven_segment_scan_driver_if #(parameter int NUM_DIGITS = 8);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic load_valid;
  logic load_ready;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic load_mode;
  logic blank_leading_zeros;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [6:0] segments;
  logic [NUM_DIGITS-1:0] digit_select;
  logic [DW-1:0] current_digit;
  logic frame_done;
  modport master (
    output load_valid, load_value, load_mode, blank_leading_zeros, blink_mask,
    input load_ready, segments, digit_select, current_digit, frame_done
  );
  modport slave (
    input load_valid, load_value, load_mode, blank_leading_zeros, blink_mask,
    output load_ready, segments, digit_select, current_digit, frame_done
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: time-multiplexed seven-segment driver with tear-free load, hex/binary decode, blanking and blink
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_DIV = 64
) (
  input logic clk,
  input logic rst,
  seven_segment_scan_driver_if.slave bus
);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [CW-1:0] dwell;
  logic [DW-1:0] digit;
  logic [VW-1:0] active, pending;
  logic active_mode, pending_mode, pending_valid;
  logic [FW-1:0] frame_cnt;
  logic blink_phase, frame_done;
  logic dwell_end, last_digit, boundary, frame_end, accept;
  logic [3:0] nibble;
  logic lz, blank;
  assign dwell_end = dwell == CW'(SCAN_DIV - 1);
  assign last_digit = digit == DW'(NUM_DIGITS - 1);
  assign boundary = dwell_end && last_digit;
  assign frame_end = frame_cnt == FW'(BLINK_DIV - 1);
  assign accept = bus.load_valid && !pending_valid;
  assign bus.load_ready = !pending_valid;
  assign bus.current_digit = digit;
  assign bus.frame_done = frame_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= '0;
      digit <= '0;
      active <= '0;
      active_mode <= 1'b0;
      pending <= '0;
      pending_mode <= 1'b0;
      pending_valid <= 1'b0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dwell <= dwell_end ? '0 : dwell + 1'b1;
      if (dwell_end) digit <= last_digit ? '0 : digit + 1'b1;
      frame_done <= boundary;
      if (boundary) begin
        frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
        if (frame_end) blink_phase <= ~blink_phase;
        if (pending_valid) begin
          active <= pending;
          active_mode <= pending_mode;
        end
      end
      // Pending only moves to Active at a frame boundary, so a frame never mixes two values
      pending_valid <= accept || (pending_valid && !boundary);
      if (accept) begin
        pending <= bus.load_value;
        pending_mode <= bus.load_mode;
      end
    end
  end
  always_comb begin
    nibble = active[{digit, 2'b00} +: 4];
    lz = digit != '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(digit) && active[4*i +: 4] != 4'd0) lz = 1'b0;
    blank = dwell == '0 || (blink_phase && bus.blink_mask[digit]) ||
            (!active_mode && bus.blank_leading_zeros && lz);
    bus.segments = blank ? 7'b1111111 :
                   active_mode ? (active[digit] ? 7'b1111001 : 7'b1000000) : HEX[nibble];
    bus.digit_select = dwell == '0 ? '1 : ~(NUM_DIGITS'(1) << digit);
  end
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb_seven_segment_scan_driver: scoreboard bench checking scan timing, decode, handshake, blink and reset
module tb_seven_segment_scan_driver;
  localparam int ND = 8;
  localparam int SD = 4;
  localparam int BD = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  int nframes;
  logic [31:0] last_v;
  logic last_m;
  logic [6:0] exp_q[$];

  seven_segment_scan_driver_if #(.NUM_DIGITS(ND)) bus();
  seven_segment_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) nframes <= 0;
    else if (bus.frame_done) nframes <= nframes + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic push_value(input logic [31:0] v, input logic m);
    for (int i = 0; i < ND; i++) begin
      logic lzb;
      lzb = i > 0 && (v >> (4 * i)) == 32'd0;
      exp_q.push_back(m ? (v[i] ? 7'b1111001 : 7'b1000000) :
                      (bus.blank_leading_zeros && lzb) ? 7'b1111111 : hex7(v[4*i +: 4]));
    end
    last_v = v;
    last_m = m;
  endtask

  task automatic do_load(input logic [31:0] v, input logic m);
    bit ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      bus.load_value = v;
      bus.load_mode = m;
      bus.load_valid = 1'b1;
      ok = bus.load_ready;
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    checks++;
    if (!ok || bus.load_ready !== 1'b0)
      $display("FAIL load_accept value=%h ok=%0b ready_after=%b required ok=1 ready_after=0", v, ok, bus.load_ready);
    else passed++;
  endtask

  task automatic wait_frame(input bit need_ready, input string name);
    bit ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.frame_done && (!need_ready || bus.load_ready);
    end
    checks++;
    if (!ok) $display("FAIL %s frame_done not seen within bound (need_ready=%0b)", name, need_ready);
    else passed++;
  endtask

  // Starts on the negedge of a FrameDone cycle and checks one full frame against the scoreboard
  task automatic check_frame(input string name);
    logic [6:0] e [ND];
    logic ph;
    checks++;
    if (exp_q.size() < ND) begin
      $display("FAIL %s scoreboard underflow size=%0d required>=%0d", name, exp_q.size(), ND);
      for (int i = 0; i < ND; i++) e[i] = 7'h7F;
    end else begin
      passed++;
      for (int i = 0; i < ND; i++) e[i] = exp_q.pop_front();
    end
    ph = 1'(((nframes + 1) / 2) % 2);
    for (int k = 0; k < ND * SD; k++) begin
      int d, w;
      logic [7:0] xsel;
      logic [6:0] xseg;
      if (k > 0) begin
        @(negedge clk);
        bus.load_valid = 1'b0;
      end
      d = k / SD;
      w = k % SD;
      xsel = w == 0 ? 8'hFF : ~(8'h01 << d);
      xseg = (w == 0 || (ph && bus.blink_mask[d])) ? 7'h7F : e[d];
      checks++;
      if ({bus.digit_select, bus.segments, bus.current_digit, bus.frame_done} !== {xsel, xseg, 3'(d), k == 0})
        $display("FAIL %s cycle=%0d sel/seg/digit/done got %h/%b/%0d/%b required %h/%b/%0d/%b",
                 name, k, bus.digit_select, bus.segments, bus.current_digit, bus.frame_done,
                 xsel, xseg, d, k == 0);
      else passed++;
    end
  endtask

  task automatic test_reset;
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.load_mode = 1'b0;
    bus.blank_leading_zeros = 1'b0;
    bus.blink_mask = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.digit_select, bus.segments, bus.current_digit, bus.load_ready, bus.frame_done} !== {8'hFF, 7'h7F, 3'd0, 1'b1, 1'b0})
      $display("FAIL reset_state sel/seg/digit/ready/done got %h/%b/%0d/%b/%b required ff/1111111/0/1/0",
               bus.digit_select, bus.segments, bus.current_digit, bus.load_ready, bus.frame_done);
    else passed++;
    rst = 1'b0;
    push_value(32'h0, 1'b0);
    wait_frame(1'b0, "reset_frame");
    check_frame("reset_display");
  endtask

  task automatic test_hex;
    bus.blank_leading_zeros = 1'b1;
    do_load(32'h000000A5, 1'b0);
    push_value(32'h000000A5, 1'b0);
    wait_frame(1'b1, "hex_apply");
    check_frame("hex_a5_blank");
  endtask

  task automatic test_binary;
    do_load(32'h5A5A5AAA, 1'b1);
    push_value(32'h5A5A5AAA, 1'b1);
    wait_frame(1'b1, "bin_apply");
    check_frame("binary_aa");
  endtask

  task automatic test_back_to_back;
    bit low_ok = 1;
    bit seen = 0;
    do_load(32'h01234567, 1'b0);
    push_value(32'h01234567, 1'b0);
    bus.load_value = 32'h00000F0D;
    bus.load_mode = 1'b0;
    bus.load_valid = 1'b1;
    push_value(32'h00000F0D, 1'b0);
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = bus.frame_done;
      if (!seen && bus.load_ready !== 1'b0) low_ok = 0;
    end
    checks++;
    if (!seen || !low_ok) $display("FAIL b2b_ready_low seen=%0b low_ok=%0b required 1/1", seen, low_ok);
    else passed++;
    checks++;
    if (bus.load_ready !== 1'b1) $display("FAIL b2b_ready_at_boundary got %b required 1", bus.load_ready);
    else passed++;
    check_frame("b2b_first");
    checks++;
    if (bus.load_ready !== 1'b0) $display("FAIL b2b_second_pending ready got %b required 0", bus.load_ready);
    else passed++;
    wait_frame(1'b1, "b2b_apply");
    check_frame("b2b_second");
  endtask

  task automatic test_free_run;
    int n = 0;
    bit seen = 0;
    wait_frame(1'b0, "free_sync");
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      n++;
      seen = bus.frame_done;
    end
    checks++;
    if (!seen || n != ND * SD) $display("FAIL frame_period got %0d required %0d", n, ND * SD);
    else passed++;
    push_value(last_v, last_m);
    check_frame("free_run");
  endtask

  task automatic test_blink;
    bus.blank_leading_zeros = 1'b0;
    bus.blink_mask = 8'h01;
    do_load(32'h1, 1'b0);
    push_value(32'h1, 1'b0);
    wait_frame(1'b1, "blink_apply");
    for (int f = 0; f < 5; f++) begin
      check_frame("blink");
      push_value(32'h1, 1'b0);
      wait_frame(1'b0, "blink_next");
    end
    exp_q.delete();
    bus.blink_mask = '0;
  endtask

  task automatic test_async_reset;
    bit at5 = 0;
    bus.blank_leading_zeros = 1'b1;
    wait_frame(1'b0, "ar_sync");
    do_load(32'h12345678, 1'b0);
    for (int t = 0; t < 100 && !at5; t++) begin
      @(negedge clk);
      at5 = bus.current_digit == 3'd5;
    end
    checks++;
    if (!at5 || bus.load_ready !== 1'b0) $display("FAIL ar_setup at5=%0b ready=%b required 1/0", at5, bus.load_ready);
    else passed++;
    #2;
    rst = 1'b1;
    bus.load_value = 32'hFFFFFFFF;
    bus.load_valid = 1'b1;
    #1;
    checks++;
    if ({bus.digit_select, bus.segments, bus.current_digit, bus.load_ready} !== {8'hFF, 7'h7F, 3'd0, 1'b1})
      $display("FAIL async_reset_instant sel/seg/digit/ready got %h/%b/%0d/%b required ff/1111111/0/1",
               bus.digit_select, bus.segments, bus.current_digit, bus.load_ready);
    else passed++;
    repeat (3) @(negedge clk);
    bus.load_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    push_value(32'h0, 1'b0);
    wait_frame(1'b1, "ar_frame");
    check_frame("after_async_reset");
  endtask

  initial begin
    test_reset();
    test_hex();
    test_binary();
    test_back_to_back();
    test_free_run();
    test_blink();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seven_segment_scan_driver.md
# seven_segment_scan_driver

Time-multiplexed seven-segment display driver, parametrised in digit count and scan rate. It replaces static per-digit outputs with one shared segment bus plus one-hot digit strobes. Adds a hex decode mode, a legacy binary 0/1 mode, leading-zero blanking, per-digit blink, and a tear-free load handshake. Sits between the CPU output register and the board display pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- SCAN_DIV, 1000, clocks per digit dwell (>=2)
- BLINK_DIV, 64, frames per blink half-period (>=1)

- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- LoadValid  in  1  load request
- LoadReady  out  1  load accepted when LoadValid && LoadReady on a rising edge
- LoadValue  in  4*NUM_DIGITS  digit i = LoadValue[4i+:4] (hex mode) or bit LoadValue[i] (binary mode); digit 0 = least significant
- LoadMode  in  1  0 = hex decode, 1 = binary 0/1 per digit; captured with LoadValue
- BlankLeadingZeros  in  1  live (not captured); hex mode only
- BlinkMask  in  NUM_DIGITS  live; bit i set = digit i blinks
- Segments  out  7  {g,f,e,d,c,b,a}, active-low
- DigitSelect  out  NUM_DIGITS  active-low one-hot strobe
- CurrentDigit  out  $clog2(NUM_DIGITS) (min 1)  digit index being scanned
- FrameDone  out  1  one-cycle pulse per completed frame

## Operation
- State registers: DwellCount (0..SCAN_DIV-1), DigitIndex (0..NUM_DIGITS-1), Active value+mode, Pending value+mode+PendingValid, FrameCount (0..BLINK_DIV-1), BlinkPhase, FrameDone.
- DwellCount increments every cycle. At SCAN_DIV-1 it wraps to 0 and DigitIndex advances. DigitIndex wraps NUM_DIGITS-1 -> 0 at the frame boundary.
- Frame boundary (DwellCount==SCAN_DIV-1 && DigitIndex==NUM_DIGITS-1):
  - if PendingValid, Active <= Pending and PendingValid <= 0;
  - FrameCount advances; at BLINK_DIV-1 it wraps and BlinkPhase toggles.
- Handshake: LoadReady = !PendingValid. An accepted load writes Pending and sets PendingValid. It never writes Active directly.
- Load accepted in the same cycle as a frame boundary with PendingValid=0: goes to Pending and is applied at the next boundary (no bypass).
- Segments and DigitSelect are combinational decodes of registered state; there is no extra output stage.
- Anti-ghost: while DwellCount==0, DigitSelect = all ones and Segments = 7'b1111111.
- Otherwise DigitSelect[DigitIndex]=0 and all other bits are 1.
- Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Binary mode: digit i shows 1111001 if Active bit i = 1, else 1000000. Upper value bits are ignored.
- Leading-zero blanking (hex mode, BlankLeadingZeros=1): digit i blanks if digits i..NUM_DIGITS-1 are all zero and i>0. Digit 0 always shows.
- Blink: BlinkPhase=1 and BlinkMask[DigitIndex]=1 -> Segments = 7'b1111111. DigitSelect is unaffected.
- Blanked digit = Segments 7'b1111111.
- Reset values: DwellCount=0, DigitIndex=0, Active=0 in hex mode, PendingValid=0 (LoadReady=1), FrameCount=0, BlinkPhase=0, FrameDone=0, CurrentDigit=0. DigitSelect is all ones and Segments is 7'b1111111 (DwellCount==0).
- Reset asserted mid-frame or mid-handshake discards Pending and Active immediately; no load is accepted while Reset=1.

## Timing
- Each digit: 1 blank cycle, then SCAN_DIV-1 cycles strobed. Frame = NUM_DIGITS*SCAN_DIV cycles.
- FrameDone is registered: high for exactly the one cycle after the frame-boundary edge.
- Load-to-display latency: from acceptance up to one frame + 1 cycle. Display is never torn within a frame.
- CurrentDigit = DigitIndex (registered); changes on the edge where DwellCount wraps.
- BlinkMask and BlankLeadingZeros take effect the same cycle they change.

## Test plan
Common settings: NUM_DIGITS=8, SCAN_DIV=4, BLINK_DIV=2.
- Reset, then load 32'h000000A5 hex with BlankLeadingZeros=1 -> after next FrameDone: digit0 strobed with 0010010, digit1 with 0001000, digits 2-7 with 1111111.
- Load 8'b10101010 in binary mode -> digits 1,3,5,7 show 1111001; digits 0,2,4,6 show 1000000.
- Back-to-back loads A then B -> LoadReady=0 after A until the boundary, then 1. A displays for one full frame, B in the following frame. No tearing: within a frame all digits come from one value.
- BlinkMask=8'h01, value 32'h1 -> digit0 shows 1111001 in frames 0-1, 1111111 in frames 2-3, 1111001 in frames 4-5.
- Free-run check -> DigitSelect pattern per digit is 1 cycle all-ones then 3 cycles one-hot low; DigitIndex runs 0..7; FrameDone pulses every 32 cycles.
- Assert Reset asynchronously at DigitIndex=5 with PendingValid=1 -> same instant: DigitSelect all ones, CurrentDigit=0, LoadReady=1. After release the display shows hex 0 on digit0.
